// File: rtl/text_cmd_ctrl.sv
// Text-plane command sequencer: opcode/parameter word pairs over valid/ready,
// 40x25 cursor tracking, and single-port character RAM writes including a full-screen clear.
module text_cmd_ctrl #(
  parameter int unsigned COLS = 40,
  parameter int unsigned ROWS = 25,
  parameter int unsigned AW   = 10
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [15:0]   cmd_data,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic [5:0]    cursor_x,
  output logic [4:0]    cursor_y,
  output logic          busy
);

  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [15:0] OP_PUTC    = 16'h00C1;
  localparam logic [15:0] OP_BKSP    = 16'h00C2;
  localparam logic [15:0] OP_SETY    = 16'h00C3;
  localparam logic [15:0] OP_SETX    = 16'h00C4;
  localparam logic [15:0] OP_CLS     = 16'h00C5;
  localparam logic [15:0] OP_NEWLINE = 16'h00C6;

  localparam logic [5:0]    X_MAX    = 6'(COLS - 1);
  localparam logic [4:0]    Y_MAX    = 5'(ROWS - 1);
  localparam logic [AW-1:0] ADDR_MAX = AW'(CELLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PARAM, S_EXEC, S_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [15:0]   opcode_q, opcode_d;
  logic [15:0]   param_q, param_d;
  logic [5:0]    cx_d;
  logic [4:0]    cy_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [7:0]    wdata_d;
  logic          xfer;
  logic [5:0]    bk_x;
  logic [4:0]    bk_y;

  function automatic logic [AW-1:0] ptr_of(input logic [5:0] x, input logic [4:0] y);
    if (COLS == 40)
      ptr_of = (AW'(y) << 5) + (AW'(y) << 3) + AW'(x);
    else
      ptr_of = AW'(y) * AW'(COLS) + AW'(x);
  endfunction

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_PARAM);
  assign busy      = (state_q != S_IDLE);
  assign xfer      = cmd_valid && cmd_ready;

  // Backspace target is needed both for the write address (PARAM edge) and the cursor update (EXEC edge).
  always_comb begin
    if (cursor_x == '0) begin
      bk_x = X_MAX;
      bk_y = (cursor_y == '0) ? Y_MAX : cursor_y - 5'd1;
    end else begin
      bk_x = cursor_x - 6'd1;
      bk_y = cursor_y;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    param_d  = param_q;
    cx_d     = cursor_x;
    cy_d     = cursor_y;
    we_d     = 1'b0;
    addr_d   = ram_addr;
    wdata_d  = ram_wdata;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          opcode_d = cmd_data;
          state_d  = S_PARAM;
        end
      end
      S_PARAM: begin
        if (xfer) begin
          param_d = cmd_data;
          if (opcode_q == OP_CLS) begin
            state_d = S_CLEAR;
            we_d    = 1'b1;
            addr_d  = '0;
            wdata_d = '0;
          end else begin
            state_d = S_EXEC;
            // Write strobe is registered here so it is valid throughout EXEC.
            if (opcode_q == OP_PUTC) begin
              we_d    = 1'b1;
              addr_d  = ptr_of(cursor_x, cursor_y);
              wdata_d = cmd_data[7:0];
            end else if (opcode_q == OP_BKSP) begin
              we_d    = 1'b1;
              addr_d  = ptr_of(bk_x, bk_y);
              wdata_d = '0;
            end
          end
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (opcode_q)
          OP_PUTC: begin
            if (cursor_x == X_MAX) begin
              cx_d = '0;
              cy_d = (cursor_y == Y_MAX) ? '0 : cursor_y + 5'd1;
            end else begin
              cx_d = cursor_x + 6'd1;
            end
          end
          OP_BKSP: begin
            cx_d = bk_x;
            cy_d = bk_y;
          end
          OP_SETY:    cy_d = (param_q > 16'(ROWS - 1)) ? Y_MAX : param_q[4:0];
          OP_SETX:    cx_d = (param_q > 16'(COLS - 1)) ? X_MAX : param_q[5:0];
          OP_NEWLINE: begin
            cx_d = '0;
            cy_d = (cursor_y == Y_MAX) ? '0 : cursor_y + 5'd1;
          end
          default: ;
        endcase
      end
      S_CLEAR: begin
        if (ram_addr == ADDR_MAX) begin
          state_d = S_IDLE;
          cx_d    = '0;
          cy_d    = '0;
        end else begin
          we_d    = 1'b1;
          addr_d  = ram_addr + AW'(1);
          wdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      param_q   <= '0;
      cursor_x  <= '0;
      cursor_y  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      param_q   <= param_d;
      cursor_x  <= cx_d;
      cursor_y  <= cy_d;
      ram_we    <= we_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_text_cmd_ctrl.sv
// Directed bench for text_cmd_ctrl: command encodings, cursor wrap/clamp, clear engine and async reset abort.
module tb_text_cmd_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  text_cmd_ctrl #(.COLS(40), .ROWS(25), .AW(10)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until it transfers; bounded wait on cmd_ready.
  task automatic xfer(input logic [15:0] w);
    int unsigned n = 0;
    cmd_valid = 1'b1;
    cmd_data  = w;
    while (!cmd_ready && n < 2000) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Leaves the bench one sample point into EXEC (or CLEAR cycle 0).
  task automatic cmd(input logic [15:0] op, input logic [15:0] p);
    xfer(op);
    xfer(p);
  endtask

  task automatic chk_cur(input string tag, input logic [5:0] x, input logic [4:0] y);
    chk({tag, "_x"}, 32'(cursor_x), 32'(x));
    chk({tag, "_y"}, 32'(cursor_y), 32'(y));
  endtask

  initial begin
    int unsigned bad;
    clr       = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_we",    32'(ram_we),    32'd0);
    chk("rst_addr",  32'(ram_addr),  32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk_cur("rst", 6'd0, 5'd0);
    @(negedge clk);
    clr = 1'b1;
    step();

    // PUTC 'A' at origin
    xfer(16'h00C1);
    chk("putc_param_busy",  32'(busy),      32'd1);
    chk("putc_param_ready", 32'(cmd_ready), 32'd1);
    chk("putc_param_we",    32'(ram_we),    32'd0);
    xfer(16'h0041);
    chk("putc_we",    32'(ram_we),    32'd1);
    chk("putc_addr",  32'(ram_addr),  32'd0);
    chk("putc_data",  32'(ram_wdata), 32'h41);
    chk("putc_ready", 32'(cmd_ready), 32'd0);
    chk_cur("putc_pre", 6'd0, 5'd0);
    step();
    chk("putc_idle_ready", 32'(cmd_ready), 32'd1);
    chk("putc_idle_we",    32'(ram_we),    32'd0);
    chk_cur("putc_post", 6'd1, 5'd0);

    // Corner write and full-screen wrap, then backspace across the wrap
    cmd(16'h00C3, 16'd24);
    chk("sety_we", 32'(ram_we), 32'd0);
    step();
    cmd(16'h00C4, 16'd39);
    step();
    chk_cur("setxy", 6'd39, 5'd24);
    cmd(16'h00C1, 16'h005A);
    chk("corner_we",   32'(ram_we),    32'd1);
    chk("corner_addr", 32'(ram_addr),  32'd999);
    chk("corner_data", 32'(ram_wdata), 32'h5A);
    step();
    chk_cur("corner_wrap", 6'd0, 5'd0);
    cmd(16'h00C2, 16'h0000);
    chk("bksp_we",   32'(ram_we),    32'd1);
    chk("bksp_addr", 32'(ram_addr),  32'd999);
    chk("bksp_data", 32'(ram_wdata), 32'h00);
    chk_cur("bksp_pre", 6'd0, 5'd0);
    step();
    chk_cur("bksp_post", 6'd39, 5'd24);

    // Newline wrap and parameter clamping on the full 16-bit value
    cmd(16'h00C6, 16'h0000);
    step();
    chk_cur("nl_wrap", 6'd0, 5'd0);
    cmd(16'h00C3, 16'h0100);
    chk("sety256_we", 32'(ram_we), 32'd0);
    step();
    chk_cur("sety_256", 6'd0, 5'd24);
    cmd(16'h00C6, 16'h0000);
    step();
    cmd(16'h00C4, 16'd100);
    chk("setx100_we", 32'(ram_we), 32'd0);
    step();
    cmd(16'h00C3, 16'hFFFF);
    chk("setyffff_we", 32'(ram_we), 32'd0);
    step();
    chk_cur("clamp", 6'd39, 5'd24);
    cmd(16'h00C6, 16'h0000);
    step();
    chk_cur("nl_clamp", 6'd0, 5'd0);

    // Clear with a queued PUTC held on the bus
    cmd(16'h00C5, 16'h0000);
    cmd_valid = 1'b1;
    cmd_data  = 16'h00C1;
    bad = 0;
    for (int unsigned i = 0; i < 1000; i++) begin
      if (ram_we !== 1'b1 || ram_addr !== 10'(i) || ram_wdata !== 8'h00 ||
          cmd_ready !== 1'b0 || busy !== 1'b1)
        bad++;
      step();
    end
    chk("cls_cycles_bad", bad, 32'd0);
    chk("cls_exit_busy",  32'(busy),      32'd0);
    chk("cls_exit_ready", 32'(cmd_ready), 32'd1);
    chk("cls_exit_we",    32'(ram_we),    32'd0);
    chk_cur("cls_exit", 6'd0, 5'd0);
    step();
    cmd_data = 16'h0031;
    chk("queued_param_busy", 32'(busy), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("queued_we",   32'(ram_we),    32'd1);
    chk("queued_addr", 32'(ram_addr),  32'd0);
    chk("queued_data", 32'(ram_wdata), 32'h31);
    step();
    chk_cur("queued_post", 6'd1, 5'd0);

    // Unknown opcode behaves as NOP through EXEC
    cmd(16'h1234, 16'h0007);
    chk("unk_we",    32'(ram_we),    32'd0);
    chk("unk_busy",  32'(busy),      32'd1);
    chk("unk_ready", 32'(cmd_ready), 32'd0);
    step();
    chk("unk_idle_busy", 32'(busy), 32'd0);
    chk_cur("unk_post", 6'd1, 5'd0);

    // Back-to-back NOPs with cmd_valid held: 3-cycle command period
    cmd_valid = 1'b1;
    cmd_data  = 16'h0000;
    step();
    chk("nop_n_busy", 32'(busy), 32'd1);
    step();
    chk("nop_n1_ready", 32'(cmd_ready), 32'd0);
    chk("nop_n1_we",    32'(ram_we),    32'd0);
    step();
    chk("nop_n2_busy", 32'(busy), 32'd0);
    step();
    chk("nop_n3_busy",  32'(busy),      32'd1);
    chk("nop_n3_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("nop_n4_ready", 32'(cmd_ready), 32'd0);
    step();
    chk_cur("nop_post", 6'd1, 5'd0);

    // Async reset in the middle of a clear
    cmd(16'h00C5, 16'h0000);
    for (int unsigned i = 0; i < 500; i++) step();
    chk("cls500_addr", 32'(ram_addr), 32'd500);
    chk("cls500_we",   32'(ram_we),   32'd1);
    #2;
    clr = 1'b0;
    #1;
    chk("abort_we",    32'(ram_we),    32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_addr",  32'(ram_addr),  32'd0);
    chk_cur("abort", 6'd0, 5'd0);
    @(negedge clk);
    clr = 1'b1;
    bad = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      step();
      if (ram_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    chk("post_abort_bad", bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_cmd_ctrl.md
# text_cmd_ctrl

Command sequencer for the GPU text plane. It accepts 16-bit opcode/parameter word pairs from the CPU over a valid/ready handshake and maintains the 40x25 text cursor. It drives single-port write cycles into the character RAM that the VGA text scanout reads. It sits between the CPU command line and the text RAM write port, and replaces ad-hoc command decoding with a defined FSM and a multi-cycle clear engine.

## Interface
- COLS, 40, characters per row
- ROWS, 25, rows per screen
- AW, 10, RAM address width; COLS*ROWS must be at most 2^AW

- clk  in  1  system clock, all state on rising edge
- clr  in  1  asynchronous, active-low reset
- cmd_data  in  16  opcode or parameter word
- cmd_valid  in  1  cmd_data valid this cycle
- cmd_ready  out  1  block accepts a word this cycle
- ram_we  out  1  text RAM write strobe, one write per cycle
- ram_addr  out  AW  text RAM address, row*COLS+col
- ram_wdata  out  8  character code to write
- cursor_x  out  6  current column, 0..COLS-1
- cursor_y  out  5  current row, 0..ROWS-1
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- A word transfers on a rising edge with cmd_valid && cmd_ready. The CPU may hold cmd_valid high. cmd_data is sampled only on a transfer.
- Commands are two words: opcode, then parameter. Every opcode consumes a parameter word, even when the parameter is unused.
- FSM states:
  - IDLE: ready=1. On transfer, latch the opcode and go to PARAM.
  - PARAM: ready=1. On transfer, latch the parameter. Go to CLEAR if opcode=0x00C5, otherwise go to EXEC.
  - EXEC: ready=0. Lasts one cycle, then goes to IDLE.
  - CLEAR: ready=0. Lasts COLS*ROWS cycles, then goes to IDLE.
- Opcodes, executed in EXEC unless stated otherwise. Here p = (x,y) is the cursor and ptr = y*COLS+x.
  - 0x0000 NOP: no write, no cursor change.
  - 0x00C1 PUTC: write param[7:0] at ptr. Then x+1. If x was COLS-1: x=0 and y+1. If y was ROWS-1: y=0 (full-screen wrap).
  - 0x00C2 BKSP: step the cursor back one cell, then write 0x00 at the new ptr. At x=0: x=COLS-1 and y-1. At (0,0): wrap to (COLS-1, ROWS-1) and write address COLS*ROWS-1.
  - 0x00C3 SETY: y = min(param, ROWS-1). x unchanged. No write.
  - 0x00C4 SETX: x = min(param, COLS-1). y unchanged. No write.
  - 0x00C5 CLS: in CLEAR, write 0x00 to addresses 0..COLS*ROWS-1 ascending, one per cycle. Cursor goes to (0,0) on exit.
  - 0x00C6 NEWLINE: x=0, y+1. At y=ROWS-1, y=0. No write.
  - Any other opcode: parameter is consumed and discarded. Behaves as NOP and still passes through EXEC.
- Address arithmetic: ram_addr = (y<<5)+(y<<3)+x when COLS=40, or a generic multiply otherwise. Computed at AW bits. The maximum value is COLS*ROWS-1, so the result never overflows.
- Parameter clamping compares the full 16-bit value. Upper bits are never silently truncated before the compare.

## Timing
- Reset values, applied immediately while clr=0: state IDLE, cmd_ready=1, ram_we=0, ram_addr=0, ram_wdata=0, cursor (0,0), busy=0, latched opcode and parameter 0.
- Minimum command period is 3 cycles: opcode at edge N, parameter at N+1, EXEC during cycle N+1..N+2, next opcode accepted at N+3.
- ram_we, ram_addr and ram_wdata are registered. They are valid during the EXEC cycle, or during each CLEAR cycle, and are low or don't-care otherwise. ram_we is never high in IDLE or PARAM.
- cursor_x and cursor_y update on the edge that leaves EXEC. During EXEC they show the pre-command position.
- For BKSP, ram_addr in EXEC already shows the decremented position.
- CLEAR of 1000 cells holds busy high for exactly 1000 cycles, and ram_addr counts 0..999. The cursor reads (0,0) on the first IDLE cycle after CLEAR.
- cmd_valid asserted during EXEC or CLEAR is ignored, with no transfer. The word transfers on the first cycle the FSM is back in IDLE.
- Reset asserted mid-CLEAR or mid-EXEC aborts immediately. No further writes occur, and the partial clear is not resumed.
- busy equals (state != IDLE), so busy is also high in PARAM.

## Test plan
- Reset, then PUTC 0x41 with cursor at (0,0) -> one cycle of ram_we with addr 0 and data 0x41. Cursor becomes (1,0). cmd_ready is low for exactly 1 cycle.
- SETY 24, SETX 39, PUTC 0x5A -> write at addr 999. Cursor wraps to (0,0). Then BKSP -> write 0x00 at addr 999 and cursor (39,24).
- SETX 100, SETY 0xFFFF -> cursor (39,24) by clamping, with no ram_we pulses. NEWLINE -> cursor (0,0).
- CLS with cmd_valid held high and a queued PUTC 0x31 -> 1000 consecutive writes of 0x00 to addrs 0..999 while cmd_ready stays low. PUTC is then accepted and writes 0x31 at addr 0.
- Opcode 0x1234 with param 0x0007 -> no write and no cursor change, and the FSM returns to IDLE after EXEC. A back-to-back NOP pair shows the 3-cycle period.
- Drop clr to 0 at CLEAR cycle 500 -> ram_we falls asynchronously and the cursor reads (0,0). After release, the FSM is in IDLE with cmd_ready=1 and no residual writes.
